// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered-read sprite ROM between NUM_REQ
// pixel requesters; returns palette indices tagged with requester id, 2-clock latency.
module sprite_rom_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int SPRITE_W    = 110,
  parameter int SPRITE_H    = 105,
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 5,
  parameter int COORD_W     = 7,
  parameter int TRANSPARENT = 0
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*COORD_W-1:0]    req_col,
  input  logic [NUM_REQ*COORD_W-1:0]    req_row,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [DATA_W-1:0]             rom_data,
  output logic                          rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [DATA_W-1:0]             rsp_data
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]    r_ptr;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic               r_s1_valid;
  logic [ID_W-1:0]    r_s1_id;
  logic               r_s1_oob;
  logic               r_s2_valid;
  logic [ID_W-1:0]    r_s2_id;
  logic               r_s2_oob;

  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [ID_W-1:0]    w_scan;
  logic               w_acc;
  logic [COORD_W-1:0] w_col;
  logic [COORD_W-1:0] w_row;
  logic               w_oob;
  logic [ADDR_W-1:0]  w_addr;

  // Scan from ptr+1 upward with wrap; the first asserted request wins.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_scan    = '0;
    w_acc     = 1'b0;
    w_col     = '0;
    w_row     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_scan = ID_W'((32'(r_ptr) + k) % NUM_REQ);
      if (!w_acc && req[w_scan]) begin
        w_acc         = 1'b1;
        w_gnt_idx     = w_scan;
        w_gnt[w_scan] = 1'b1;
        w_col         = req_col[32'(w_scan)*COORD_W +: COORD_W];
        w_row         = req_row[32'(w_scan)*COORD_W +: COORD_W];
      end
    end
  end

  assign w_oob  = (int'(w_col) >= SPRITE_W) || (int'(w_row) >= SPRITE_H);
  assign w_addr = ADDR_W'(w_row) * ADDR_W'(SPRITE_W) + ADDR_W'(w_col);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ptr      <= ID_W'(NUM_REQ - 1);
      r_rom_addr <= '0;
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s1_oob   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_id    <= '0;
      r_s2_oob   <= 1'b0;
    end else begin
      r_s1_valid <= w_acc;
      if (w_acc) begin
        r_ptr    <= w_gnt_idx;
        r_s1_id  <= w_gnt_idx;
        r_s1_oob <= w_oob;
        // Out-of-bounds requests leave the ROM address untouched.
        if (!w_oob) r_rom_addr <= w_addr;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_id  <= r_s1_id;
        r_s2_oob <= r_s1_oob;
      end
    end
  end

  assign gnt       = w_gnt;
  assign rom_addr  = r_rom_addr;
  assign rsp_valid = r_s2_valid;
  assign rsp_id    = r_s2_id;
  assign rsp_data  = r_s2_oob ? DATA_W'(TRANSPARENT) : rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a registered ROM model whose
// contents are mem[a] = (7*a + 3) mod 32.
module tb_sprite_rom_arbiter;

  logic        Clk;
  logic        Reset_n;
  logic [3:0]  req;
  logic [27:0] req_col;
  logic [27:0] req_row;
  logic [3:0]  gnt;
  logic [13:0] rom_addr;
  logic [4:0]  rom_data;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [4:0]  rsp_data;

  int n_vec;
  int n_err;

  sprite_rom_arbiter #(
    .NUM_REQ(4), .SPRITE_W(110), .SPRITE_H(105),
    .ADDR_W(14), .DATA_W(5), .COORD_W(7), .TRANSPARENT(0)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .req_col(req_col), .req_row(req_row),
    .gnt(gnt), .rom_addr(rom_addr), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) rom_data <= 5'(32'(rom_addr) * 7 + 3);

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic set_coord(input int i, input int col, input int row);
    req_col[i*7 +: 7] = 7'(col);
    req_row[i*7 +: 7] = 7'(row);
  endtask

  task automatic chk_rsp(input string tag, input int id, input int data);
    chk({tag, "_valid"}, 32'(rsp_valid), 1);
    chk({tag, "_id"},    32'(rsp_id),    32'(id));
    chk({tag, "_data"},  32'(rsp_data),  32'(data));
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    Reset_n = 1'b0;
    req     = '0;
    req_col = '0;
    req_row = '0;
    #12;
    chk("rst_rom_addr",  32'(rom_addr),  0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id",    32'(rsp_id),    0);
    chk("rst_gnt",       32'(gnt),       0);
    Reset_n = 1'b1;

    // 1: idle after reset release
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_gnt",       32'(gnt),       0);
      chk("idle_rsp_valid", 32'(rsp_valid), 0);
      chk("idle_rom_addr",  32'(rom_addr),  0);
    end

    // 2: lone request, col=5 row=2 -> addr 225, mem[225]=10
    set_coord(0, 5, 2);
    req = 4'b0001;
    #1 chk("t2_gnt", 32'(gnt), 4'b0001);
    tick();
    req = '0;
    chk("t2_rom_addr",  32'(rom_addr),  225);
    chk("t2_early_rsp", 32'(rsp_valid), 0);
    tick();
    chk_rsp("t2_rsp", 0, 10);
    tick();
    chk("t2_rsp_done", 32'(rsp_valid), 0);

    // restart arbitration at requester 0
    Reset_n = 1'b0;
    #2 Reset_n = 1'b1;
    tick();

    // 3: all four held; requester i at (i,1) -> addr 110+i, data 5+7i
    for (int i = 0; i < 4; i++) set_coord(i, i, 1);
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1 chk("t3_gnt", 32'(gnt), 32'(1) << (c % 4));
      tick();
      chk("t3_rom_addr", 32'(rom_addr), 32'(110 + c % 4));
      if (c == 0) chk("t3_first_rsp", 32'(rsp_valid), 0);
      else        chk_rsp("t3_rsp", (c - 1) % 4, 5 + 7 * ((c - 1) % 4));
    end
    req = '0;
    tick();
    chk_rsp("t3_last_rsp", 3, 26);
    tick();
    chk("t3_drain", 32'(rsp_valid), 0);

    // 4: out-of-bounds col=110 then in-range corner (109,104) -> 11549, mem=14
    set_coord(2, 110, 0);
    req = 4'b0100;
    #1 chk("t4_gnt_oob", 32'(gnt), 4'b0100);
    tick();
    chk("t4_addr_hold", 32'(rom_addr), 113);
    set_coord(2, 109, 104);
    #1 chk("t4_gnt_in", 32'(gnt), 4'b0100);
    tick();
    req = '0;
    chk("t4_rom_addr", 32'(rom_addr), 11549);
    chk_rsp("t4_rsp_oob", 2, 0);
    tick();
    chk_rsp("t4_rsp_in", 2, 14);
    tick();
    chk("t4_drain",   32'(rsp_valid), 0);
    chk("t4_id_hold", 32'(rsp_id),    2);

    // 5: reset with two requests in flight
    set_coord(2, 2, 1);
    req = 4'b1111;
    #1 chk("t5_gnt_a", 32'(gnt), 4'b1000);
    tick();
    chk("t5_gnt_b", 32'(gnt), 4'b0001);
    tick();
    Reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(rsp_valid), 0);
    chk("t5_rst_addr",  32'(rom_addr),  0);
    chk("t5_rst_id",    32'(rsp_id),    0);
    tick();
    Reset_n = 1'b1;
    #1 chk("t5_gnt_after", 32'(gnt), 4'b0001);
    chk("t5_valid_after", 32'(rsp_valid), 0);
    req = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_no_rsp", 32'(rsp_valid), 0);
    end

    // 6: requester 1 withdraws while 3 stays held
    req = 4'b1011;
    #1 chk("t6_gnt_0", 32'(gnt), 4'b0001);
    tick();
    req = 4'b1001;
    #1 chk("t6_gnt_3", 32'(gnt), 4'b1000);
    tick();
    req = '0;
    chk_rsp("t6_rsp_0", 0, 5);
    tick();
    chk_rsp("t6_rsp_3", 3, 26);
    tick();
    chk("t6_drain", 32'(rsp_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
